// File: rtl/t_counter_pkg.sv
// rtl/t_counter_pkg.sv - mode encoding and terminal-value helper for t_counter_n
package t_counter_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    // Value at which a count in the given direction wraps on the next advance.
    function automatic int terminal_value(input logic count_up, input int modulus);
        return count_up ? modulus - 1 : 0;
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single-bit toggle cell with synchronous active-high reset
module t_ff_cell #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic qbar
);

    logic q_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_VAL;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q    = q_q;
    assign qbar = ~q_q;

endmodule

// File: rtl/t_counter_n.sv
// rtl/t_counter_n.sv - WIDTH-bit toggle register / modulo-N up-down counter built from T cells
module t_counter_n
    import t_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 2**WIDTH,
    parameter int RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so that MODULUS = 2**WIDTH is representable.
    localparam logic [WIDTH:0]   MOD_W   = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0]   TERM_UP = (WIDTH+1)'(terminal_value(1'b1, MODULUS));
    localparam logic [WIDTH:0]   TERM_DN = (WIDTH+1)'(terminal_value(1'b0, MODULUS));
    localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RST_VAL);

    mode_e            mode_s;
    logic [WIDTH:0]   q_ext;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic             wrap_d;
    logic             wrap_q;

    assign mode_s = mode_e'(mode);
    assign q_ext  = {1'b0, q};

    always_comb begin
        q_next = q;
        wrap_d = 1'b0;
        if (load) begin
            q_next = d;
        end else if (en) begin
            case (mode_s)
                MODE_HOLD:   q_next = q;
                MODE_TOGGLE: q_next = q ^ t;
                MODE_UP: begin
                    if (q_ext >= TERM_UP) begin
                        q_next = '0;
                        wrap_d = 1'b1;
                    end else begin
                        q_next = q + WIDTH'(1);
                    end
                end
                MODE_DOWN: begin
                    if (q_ext == TERM_DN || q_ext >= MOD_W) begin
                        q_next = TERM_UP[WIDTH-1:0];
                        wrap_d = 1'b1;
                    end else begin
                        q_next = q - WIDTH'(1);
                    end
                end
            endcase
        end
    end

    // Out-of-range values never match, so tc stays low on their corrective wrap.
    always_comb begin
        tc = 1'b0;
        if (en) begin
            if (mode_s == MODE_UP && q_ext == TERM_UP) begin
                tc = 1'b1;
            end else if (mode_s == MODE_DOWN && q_ext == TERM_DN) begin
                tc = 1'b1;
            end
        end
    end

    // Every non-reset update, including load, reaches the cells as a toggle mask.
    assign t_vec = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell #(
            .RST_VAL (RST_V[i])
        ) u_cell (
            .clk  (clk),
            .rst  (rst),
            .t    (t_vec[i]),
            .q    (q[i]),
            .qbar (qbar[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule
